// File: rtl/mips_boot_sequencer.sv
// mips_boot_sequencer: streams a program into imem, holds then releases CPU reset,
// and reports done on a PC branch-to-self halt or on cycle-budget timeout.
module mips_boot_sequencer #(
  parameter int          IMEM_AW     = 8,
  parameter int          RESET_HOLD  = 3,
  parameter int          HALT_REPEAT = 4,
  parameter logic [31:0] MAX_CYCLES  = 32'd100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_data,
  input  logic               ld_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_reset,
  input  logic [31:0]        pc,
  output logic               done,
  output logic               halted,
  output logic               timeout,
  output logic               overflow,
  output logic [31:0]        cycle_count
);
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [31:0]        hold_q, hold_d, stable_q, stable_d, pc_prev_q, pc_prev_d;
  logic [31:0]        wdata_q, wdata_d, cycle_q, cycle_d;
  logic               first_q, first_d, ld_ready_q, ld_ready_d, we_q, we_d, cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d, halted_q, halted_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic               hs;
  assign hs = ld_valid && ld_ready_q;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    stable_d    = stable_q;
    pc_prev_d   = pc_prev_q;
    wdata_d     = wdata_q;
    cycle_d     = cycle_q;
    first_d     = first_q;
    ld_ready_d  = ld_ready_q;
    we_d        = 1'b0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d     = LOAD;
        idx_d       = '0;
        ld_ready_d  = 1'b1;
        cpu_reset_d = 1'b1;
        done_d      = 1'b0;
        halted_d    = 1'b0;
        timeout_d   = 1'b0;
        overflow_d  = 1'b0;
        cycle_d     = '0;
      end
      LOAD: if (hs) begin
        we_d    = 1'b1;
        addr_d  = idx_q;
        wdata_d = ld_data;
        idx_d   = idx_q + 1'b1;
        // The last imem slot ends the load even without ld_last, so idx never wraps in use.
        if (ld_last || &idx_q) begin
          state_d    = HOLD;
          ld_ready_d = 1'b0;
          overflow_d = !ld_last;
          hold_d     = '0;
        end
      end
      HOLD: if (hold_q == 32'(RESET_HOLD)) begin
        state_d     = RUN;
        cpu_reset_d = 1'b0;
        first_d     = 1'b1;
        stable_d    = '0;
      end else begin
        hold_d = hold_q + 32'd1;
      end
      RUN: begin
        cycle_d   = cycle_q + 32'd1;
        pc_prev_d = pc;
        first_d   = 1'b0;
        stable_d  = (!first_q && pc == pc_prev_q) ? stable_q + 32'd1 : '0;
        if (stable_d == 32'(HALT_REPEAT)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          halted_d = 1'b1;
        end else if (cycle_d == MAX_CYCLES) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      stable_q    <= '0;
      pc_prev_q   <= '0;
      wdata_q     <= '0;
      cycle_q     <= '0;
      first_q     <= 1'b0;
      ld_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      stable_q    <= stable_d;
      pc_prev_q   <= pc_prev_d;
      wdata_q     <= wdata_d;
      cycle_q     <= cycle_d;
      first_q     <= first_d;
      ld_ready_q  <= ld_ready_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
    end
  end
  assign ld_ready    = ld_ready_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_q;
endmodule

// File: tb/tb_mips_boot_sequencer.sv
// tb_mips_boot_sequencer: randomized load/run scenarios checked against a transaction-level model.
module tb_mips_boot_sequencer;
  localparam int AW = 5, DEPTH = 1 << AW, RH = 3, HR = 4, MC = 100;
  logic clk = 1'b0, reset, start, ld_valid, ld_last;
  logic [31:0] ld_data, pc;
  logic ld_ready, imem_we, cpu_reset, done, halted, timeout, overflow;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata, cycle_count;
  int n_cmp = 0, n_bad = 0;
  mips_boot_sequencer #(.IMEM_AW(AW), .RESET_HOLD(RH), .HALT_REPEAT(HR), .MAX_CYCLES(32'(MC))) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .pc(pc), .done(done), .halted(halted),
    .timeout(timeout), .overflow(overflow), .cycle_count(cycle_count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, 1);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_flags"}, {done, halted, timeout, overflow}, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ld_ready", ld_ready, 1);
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_flags", {done, halted, timeout, overflow}, 0);
    chk("start_cycle_count", cycle_count, 0);
  endtask
  // Offer n words with gmin..gmax idle cycles after each accepted word; the model is
  // simply "min(n, DEPTH) words land at 0.. one cycle after their handshake".
  task automatic load_prog(input int n, input bit use_last, input int gmin, input int gmax);
    logic [31:0] w[$];
    int k = 0, gl = 0, t = 0, c = 0;
    bit hs, lst, fin = 0, exp_ovf;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    exp_ovf = !use_last || n > DEPTH;
    while (!fin && t < 4000) begin
      ld_valid = (k < n) && gl == 0;
      ld_data = $urandom;
      if (k < n) ld_data = w[k];
      ld_last = ld_valid && use_last && k == n - 1;
      hs = ld_valid && ld_ready;
      lst = ld_last;
      step();
      t++;
      chk("imem_we", imem_we, hs);
      if (hs) begin
        chk("imem_addr", imem_addr, k);
        chk("imem_wdata", imem_wdata, w[k]);
        k++;
        fin = lst || k == DEPTH;
        gl = $urandom_range(gmin, gmax);
      end else if (gl > 0) gl--;
    end
    chk("load_finished", fin, 1);
    chk("words_written", k, (n < DEPTH) ? n : DEPTH);
    chk("ld_ready_drop", ld_ready, 0);
    chk("overflow", overflow, exp_ovf);
    t = 0;
    while (cpu_reset && t < 50) begin
      ld_valid = k < n;
      ld_data = $urandom;
      ld_last = 1'b0;
      step();
      t++;
      chk("hold_imem_we", imem_we, 0);
      chk("hold_ld_ready", ld_ready, 0);
      if (cpu_reset) c++;
    end
    chk("hold_len", c, RH);
    ld_valid = 1'b0;
  endtask
  // mode 0: isort halt, 1: pc+=4 timeout, 2: random {0,4}, 3: halt on the budget's last cycle
  task automatic run_prog(input int mode);
    logic [31:0] s[$];
    int exp_end = MC, i = 0;
    bit exp_halt = 0, eq;
    for (int j = 0; j < MC + 10; j++)
      case (mode)
        0:       s.push_back(j < 3 ? 32'(4 * j) : 32'h78);
        1:       s.push_back(32'(4 * j));
        2:       s.push_back(32'($urandom_range(0, 1) * 4));
        default: s.push_back(j < MC - 1 - HR ? 32'(4 * j) : 32'h0ff0);
      endcase
    // Halt = first cycle whose pc equals each of the previous HR pcs, within the budget.
    for (int j = HR; j < MC && !exp_halt; j++) begin
      eq = 1;
      for (int m = 1; m <= HR; m++) if (s[j-m] != s[j]) eq = 0;
      if (eq) begin
        exp_halt = 1;
        exp_end = j + 1;
      end
    end
    while (!done && i < MC + 5) begin
      pc = s[i];
      start = (i == 2);
      step();
      i++;
      chk("run_cpu_reset", cpu_reset, 0);
      chk("run_cycle_count", cycle_count, i);
    end
    start = 1'b0;
    chk("end_cycle", i, exp_end);
    chk("done", done, 1);
    chk("halted", halted, exp_halt);
    chk("timeout", timeout, !exp_halt);
    for (int j = 0; j < 3; j++) begin
      pc = $urandom;
      step();
      chk("done_hold", {done, halted, timeout, cpu_reset}, {1'b1, exp_halt, !exp_halt, 1'b0});
      chk("done_cycle_count", cycle_count, exp_end);
    end
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_data = '0;
    pc = '0;
    step();
    step();
    check_reset("por");
    reset = 1'b0;
    step();
    chk("idle_cpu_reset", cpu_reset, 1);
    do_start();
    load_prog(31, 1, 0, 0);
    run_prog(0);
    do_start();
    load_prog(20, 1, 1, 5);
    run_prog(1);
    do_start();
    load_prog(40, 0, 0, 2);
    run_prog(2);
    do_start();
    load_prog(DEPTH, 1, 0, 1);
    run_prog(3);
    do_start();
    for (int j = 0; j < 5; j++) begin
      ld_valid = 1'b1;
      ld_data = $urandom;
      step();
    end
    reset = 1'b1;
    step();
    check_reset("rst_load");
    reset = 1'b0;
    ld_valid = 1'b0;
    do_start();
    load_prog(6, 1, 0, 3);
    for (int j = 0; j < 10; j++) begin
      pc = $urandom;
      step();
    end
    reset = 1'b1;
    step();
    check_reset("rst_run");
    reset = 1'b0;
    do_start();
    load_prog(12, 1, 0, 0);
    run_prog(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
